// File: rtl/round_if.sv
// Bus bundle for the round block: one qualified product significand in,
// one rounded significand with status flags out.
interface round_if #(
    parameter int NSIG = 7
);
    logic              in_valid;
    logic [2*NSIG+1:0] pSig;
    logic              out_valid;
    logic [NSIG-1:0]   roundedSig;
    logic              overflow;
    logic              inexact;

    // Producer side: drives the unrounded significand, observes results.
    modport master (
        output in_valid,
        output pSig,
        input  out_valid,
        input  roundedSig,
        input  overflow,
        input  inexact
    );

    // Rounder side: consumes the significand, drives registered results.
    modport slave (
        input  in_valid,
        input  pSig,
        output out_valid,
        output roundedSig,
        output overflow,
        output inexact
    );
endinterface

// File: rtl/round.sv
// Round-to-nearest, ties-to-even rounder for a 2*NSIG+2 bit product
// significand. Keeps NSIG bits, reports the carry out of the increment
// and whether any discarded bit was set. One register stage, no stall.
module round #(
    parameter int NSIG = 7
) (
    input  logic   clk,
    input  logic   rst,
    round_if.slave bus
);

    // Packed result layout: {inexact, overflow, roundedSig}.
    localparam int RES_W = NSIG + 2;

    // Splits the significand into retained/guard/round/sticky fields and
    // applies RNE. The product MSB is not part of any field. On a carry
    // out the low NSIG bits of the sum are already zero, so no extra
    // clearing of the retained field is needed and nothing is renormalized.
    function automatic logic [RES_W-1:0] round_rne(input logic [2*NSIG+1:0] p);
        logic [NSIG-1:0] kept;
        logic            lsb;
        logic            guard;
        logic            rbit;
        logic            sticky;
        logic            inc;
        logic [NSIG:0]   sum;
        kept   = p[2*NSIG:NSIG+1];
        lsb    = p[NSIG+1];
        guard  = p[NSIG];
        rbit   = p[NSIG-1];
        sticky = |p[NSIG-2:0];
        inc    = guard & (rbit | sticky | lsb);
        sum    = {1'b0, kept} + {{NSIG{1'b0}}, inc};
        return {(guard | rbit | sticky), sum[NSIG], sum[NSIG-1:0]};
    endfunction

    logic [RES_W-1:0] res_p0;
    logic             vld_p1;
    logic [NSIG-1:0]  sig_p1;
    logic             ovf_p1;
    logic             inx_p1;

    // Stage 0: combinational rounding of the incoming significand.
    assign res_p0 = round_rne(bus.pSig);

    // Stage 1: result registers; data only loads on a valid input so an
    // idle bus (even with an undefined pSig) leaves the last result held.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            sig_p1 <= '0;
            ovf_p1 <= 1'b0;
            inx_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                sig_p1 <= res_p0[NSIG-1:0];
                ovf_p1 <= res_p0[NSIG];
                inx_p1 <= res_p0[NSIG+1];
            end
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.roundedSig = sig_p1;
    assign bus.overflow   = ovf_p1;
    assign bus.inexact    = inx_p1;

endmodule

// File: tb/tb_round.sv
// Self-checking bench for the round block (NSIG = 7, 16-bit significand).
// The reference treats the discarded low bits as a remainder compared
// against one half ULP and rounds the retained integer accordingly.
module tb_round;

    localparam int NSIG = 7;
    localparam int PW   = 2*NSIG + 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Expected outputs currently held by the DUT.
    logic [NSIG-1:0] e_sig;
    logic            e_ovf;
    logic            e_inx;
    logic            e_vld;

    round_if #(.NSIG(NSIG)) bus ();

    round #(.NSIG(NSIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rounding: integer retained value plus remainder vs. half.
    task automatic model(input logic [PW-1:0] p, output logic [NSIG-1:0] s,
                         output logic o, output logic i);
        int pv, r, rem, half, sum;
        pv   = int'(p);
        r    = (pv >> (NSIG + 1)) % (1 << NSIG);
        rem  = pv % (1 << (NSIG + 1));
        half = 1 << NSIG;
        sum  = r;
        if (rem > half || (rem == half && (r % 2) == 1))
            sum = r + 1;
        o = (sum >= (1 << NSIG));
        s = NSIG'(sum % (1 << NSIG));
        i = (rem != 0);
    endtask

    // Present one bus cycle; updates the expected state per the model.
    task automatic drive(input logic v, input logic [PW-1:0] p);
        bus.in_valid = v;
        bus.pSig     = v ? p : 'x;
        if (v) model(p, e_sig, e_ovf, e_inx);
        e_vld = v;
        step();
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.pSig     = 16'hFF80;
        step();
        step();
        e_vld = 0; e_sig = '0; e_ovf = 0; e_inx = 0;
        total++;
        if ({bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig} !== 10'b0) begin
            bad++;
            $display("FAIL reset_state got v=%b o=%b i=%b s=%b want all zero",
                     bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_vectors();
        logic [PW-1:0]   vec [7];
        logic [NSIG-1:0] want_s [7];
        logic            want_o [7];
        logic            want_i [7];
        vec = '{16'h0000, 16'h01C0, 16'h0181, 16'h0280, 16'h0380, 16'hFF80, 16'hFEC0};
        want_s = '{7'b0000000, 7'b0000010, 7'b0000010, 7'b0000010,
                   7'b0000100, 7'b0000000, 7'b1111111};
        want_o = '{0, 0, 0, 0, 0, 1, 0};
        want_i = '{0, 1, 1, 1, 1, 1, 1};
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, vec[k]);
            total++;
            if ({bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig}
                !== {1'b1, want_o[k], want_i[k], want_s[k]}) begin
                bad++;
                $display("FAIL vector_%h got v=%b o=%b i=%b s=%b want v=1 o=%b i=%b s=%b",
                         vec[k], bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig,
                         want_o[k], want_i[k], want_s[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] p;
        logic          v;
        for (int k = 0; k < 60; k++) begin
            v = ($urandom % 4) != 0;
            p = PW'($urandom);
            // Bias some samples toward exact ties and near-overflow values.
            if (k % 5 == 0) p[NSIG-1:0] = '0;
            if (k % 7 == 0) p[2*NSIG:NSIG+1] = '1;
            drive(v, p);
            total++;
            if ({bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig}
                !== {e_vld, e_ovf, e_inx, e_sig}) begin
                bad++;
                $display("FAIL random_%0d p=%h v=%b got v=%b o=%b i=%b s=%b want v=%b o=%b i=%b s=%b",
                         k, p, v, bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig,
                         e_vld, e_ovf, e_inx, e_sig);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] seq [3];
        seq = '{16'h0380, 16'h01C0, 16'hFEC0};
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1'b1, seq[k]);
            else       drive(1'b0, '0);
            total++;
            if ({bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig}
                !== {e_vld, e_ovf, e_inx, e_sig}) begin
                bad++;
                $display("FAIL b2b_%0d got v=%b o=%b i=%b s=%b want v=%b o=%b i=%b s=%b",
                         k, bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig,
                         e_vld, e_ovf, e_inx, e_sig);
            end
        end
    endtask

    task automatic test_reset_priority();
        // Load a nonzero result, then reset with a valid input pending.
        drive(1'b1, 16'hFF80);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.pSig     = 16'h0380;
        step();
        e_vld = 0; e_sig = '0; e_ovf = 0; e_inx = 0;
        total++;
        if ({bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig} !== 10'b0) begin
            bad++;
            $display("FAIL reset_priority got v=%b o=%b i=%b s=%b want all zero",
                     bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig);
        end
        rst = 1'b0;
        drive(1'b0, '0);
        total++;
        if ({bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig} !== 10'b0) begin
            bad++;
            $display("FAIL reset_discard got v=%b o=%b i=%b s=%b want all zero",
                     bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig);
        end
        // First valid input after reset release.
        drive(1'b1, 16'h0181);
        total++;
        if ({bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig}
            !== {1'b1, 1'b0, 1'b1, 7'b0000010}) begin
            bad++;
            $display("FAIL first_after_reset got v=%b o=%b i=%b s=%b want v=1 o=0 i=1 s=0000010",
                     bus.out_valid, bus.overflow, bus.inexact, bus.roundedSig);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.pSig     = '0;
        e_vld = 0; e_sig = '0; e_ovf = 0; e_inx = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
